// File: rtl/pipe_trace_pkg.sv
// Shared entry type and helpers for the pipeline trace tracker.
// Entry fields are sized for the widest legal configuration; the top zero-extends and truncates.
package pipe_trace_pkg;

    localparam int TE_PC_MAX    = 32;
    localparam int TE_CYC_MAX   = 64;
    localparam int TE_STALL_MAX = 16;

    typedef struct packed {
        logic                    valid;
        logic [TE_PC_MAX-1:0]    pc;
        logic [TE_CYC_MAX-1:0]   fetch_cyc;
        logic [TE_STALL_MAX-1:0] stall_cnt;
    } trace_entry_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    // Saturates at 2^w-1 so narrow stall counters behave as if they were w bits wide.
    function automatic logic [TE_STALL_MAX-1:0] sat_inc(input logic [TE_STALL_MAX-1:0] v,
                                                       input int unsigned w);
        logic [TE_STALL_MAX-1:0] lim;
        lim = TE_STALL_MAX'((32'd1 << w) - 32'd1);
        return (v >= lim) ? v : v + TE_STALL_MAX'(1);
    endfunction

endpackage

// File: rtl/pipe_trace_stage.sv
// One tracked pipeline stage: holds, squashes, takes a bubble or loads its upstream entry.
module pipe_trace_stage
    import pipe_trace_pkg::*;
#(
    parameter int STALL_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_hold,
    input  logic         i_squash,
    input  logic         i_load_bubble,
    input  trace_entry_t i_entry,
    output trace_entry_t o_entry
);

    trace_entry_t r_entry;

    // i_squash only matters while holding; a moving squashed entry is masked upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry <= '0;
        end else if (i_load_bubble) begin
            r_entry <= '0;
        end else if (i_hold) begin
            if (i_squash) begin
                r_entry <= '0;
            end else if (r_entry.valid) begin
                r_entry.stall_cnt <= sat_inc(r_entry.stall_cnt, STALL_W);
            end
        end else begin
            r_entry <= i_entry;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/pipeline_trace_tracker.sv
// Instruction-lifetime tracker: shadows pipeline stages under stall/flush and
// emits a registered record for every retired instruction plus running totals.
module pipeline_trace_tracker
    import pipe_trace_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int STALL_DEPTH = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int PC_W        = 16,
    parameter int CYC_W       = 32,
    parameter int STALL_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_valid,
    input  logic [PC_W-1:0]                 fetch_pc,
    input  logic                            stall,
    input  logic                            flush,
    output logic                            fetch_ready,
    output logic                            retire_valid,
    output logic [PC_W-1:0]                 retire_pc,
    output logic [CYC_W-1:0]                retire_fetch_cyc,
    output logic [CYC_W-1:0]                retire_cyc,
    output logic [STALL_W-1:0]              retire_stall_cnt,
    output logic [$clog2(NUM_STAGES+1)-1:0] occupancy,
    output logic [CYC_W-1:0]                retired_total,
    output logic [CYC_W-1:0]                squashed_total,
    output logic [CYC_W-1:0]                cyc_cnt
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);
    localparam int LAST  = NUM_STAGES - 1;

    if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("NUM_STAGES must be in 2..8");
    end
    if (STALL_DEPTH < 1 || STALL_DEPTH > NUM_STAGES - 1) begin : g_bad_stall_depth
        $error("STALL_DEPTH must be in 1..NUM_STAGES-1");
    end
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES - 1) begin : g_bad_flush_depth
        $error("FLUSH_DEPTH must be in 1..NUM_STAGES-1");
    end
    if (PC_W < 1 || PC_W > TE_PC_MAX || CYC_W < 1 || CYC_W > TE_CYC_MAX ||
        STALL_W < 1 || STALL_W > TE_STALL_MAX) begin : g_bad_widths
        $error("PC_W, CYC_W or STALL_W outside supported range");
    end

    logic [CYC_W-1:0]      r_cyc_cnt;
    logic                  r_retire_valid;
    logic [PC_W-1:0]       r_retire_pc;
    logic [CYC_W-1:0]      r_retire_fetch_cyc;
    logic [CYC_W-1:0]      r_retire_cyc;
    logic [STALL_W-1:0]    r_retire_stall_cnt;
    logic [CYC_W-1:0]      r_retired_total;
    logic [CYC_W-1:0]      r_squashed_total;

    trace_entry_t          w_stage_q [NUM_STAGES];
    trace_entry_t          w_in      [NUM_STAGES];
    trace_entry_t          w_fetch_entry;
    logic [NUM_STAGES-1:0] w_hold;
    logic [NUM_STAGES-1:0] w_squash;
    logic [NUM_STAGES-1:0] w_bubble;
    logic [7:0]            w_valid_q;
    logic [7:0]            w_kill;

    always_comb begin
        w_fetch_entry           = '0;
        w_fetch_entry.valid     = fetch_valid && !stall;
        w_fetch_entry.pc        = TE_PC_MAX'(fetch_pc);
        w_fetch_entry.fetch_cyc = TE_CYC_MAX'(r_cyc_cnt);
    end

    // Per-stage controls; an entry killed by flush never propagates to the next stage.
    always_comb begin
        w_hold    = '0;
        w_squash  = '0;
        w_bubble  = '0;
        w_valid_q = '0;
        w_kill    = '0;
        w_in[0]   = w_fetch_entry;
        for (int s = 0; s < NUM_STAGES; s++) begin
            w_hold[s]    = stall && (s < STALL_DEPTH);
            w_squash[s]  = flush && (s < FLUSH_DEPTH);
            w_bubble[s]  = stall && (s == STALL_DEPTH);
            w_valid_q[s] = w_stage_q[s].valid;
            w_kill[s]    = w_stage_q[s].valid && w_squash[s];
        end
        for (int s = 1; s < NUM_STAGES; s++) begin
            w_in[s]       = w_stage_q[s-1];
            w_in[s].valid = w_stage_q[s-1].valid && !w_squash[s-1];
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        pipe_trace_stage #(
            .STALL_W (STALL_W)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .i_hold        (w_hold[s]),
            .i_squash      (w_squash[s]),
            .i_load_bubble (w_bubble[s]),
            .i_entry       (w_in[s]),
            .o_entry       (w_stage_q[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt          <= '0;
            r_retire_valid     <= 1'b0;
            r_retire_pc        <= '0;
            r_retire_fetch_cyc <= '0;
            r_retire_cyc       <= '0;
            r_retire_stall_cnt <= '0;
            r_retired_total    <= '0;
            r_squashed_total   <= '0;
        end else begin
            r_cyc_cnt        <= r_cyc_cnt + CYC_W'(1);
            r_squashed_total <= r_squashed_total + CYC_W'(popcount8(w_kill));
            r_retire_valid   <= w_stage_q[LAST].valid;
            if (w_stage_q[LAST].valid) begin
                r_retire_pc        <= w_stage_q[LAST].pc[PC_W-1:0];
                r_retire_fetch_cyc <= w_stage_q[LAST].fetch_cyc[CYC_W-1:0];
                r_retire_cyc       <= r_cyc_cnt;
                r_retire_stall_cnt <= w_stage_q[LAST].stall_cnt[STALL_W-1:0];
                r_retired_total    <= r_retired_total + CYC_W'(1);
            end
        end
    end

    assign fetch_ready      = !stall;
    assign retire_valid     = r_retire_valid;
    assign retire_pc        = r_retire_pc;
    assign retire_fetch_cyc = r_retire_fetch_cyc;
    assign retire_cyc       = r_retire_cyc;
    assign retire_stall_cnt = r_retire_stall_cnt;
    assign occupancy        = OCC_W'(popcount8(w_valid_q));
    assign retired_total    = r_retired_total;
    assign squashed_total   = r_squashed_total;
    assign cyc_cnt          = r_cyc_cnt;

endmodule
